// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: datapath sizes, FSM states and the
// commit record carried by both the exec and dmem result paths.
package writeback_stage_pkg;
    localparam int BIN_DIG = 32;
    localparam int REG_NUM = 32;

    typedef enum logic [1:0] {WB_RUN, WB_HOLD, WB_HALT} wb_state_t;

    typedef struct packed {
        logic [4:0]         rd;
        logic               rd_we;
        logic [BIN_DIG-1:0] rd_value;
        logic [BIN_DIG-1:0] pc;
        logic [BIN_DIG-1:0] next_pc;
    } commit_t;
endpackage

// File: rtl/writeback_stage_regfile.sv
// Architectural general register file: one write port, whole file exported
// flat, x0 never written and always read as zero.
module writeback_stage_regfile
    import writeback_stage_pkg::*;
#(
    parameter int DW = BIN_DIG,
    parameter int NR = REG_NUM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [DW-1:0]    wdata,
    output logic [NR*DW-1:0] rdata
);
    logic [NR-1:0][DW-1:0] regs;

    always_ff @(posedge clk) begin
        if (!rst_n)
            regs <= '0;
        else if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    always_comb begin
        rdata         = regs;
        rdata[DW-1:0] = '0;
    end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits exec/dmem results into the register file and
// PC, raises redirect pulses on non-sequential flow, counts retired insns.
module writeback_stage #(
    parameter int                 BIN_DIG  = 32,
    parameter int                 REG_NUM  = 32,
    parameter logic [BIN_DIG-1:0] RESET_PC = '0,
    parameter int                 CNT_W    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [4:0]                 ex_rd,
    input  logic                       ex_rd_we,
    input  logic [BIN_DIG-1:0]         ex_rd_value,
    input  logic [BIN_DIG-1:0]         ex_pc,
    input  logic [BIN_DIG-1:0]         ex_next_pc,
    input  logic                       dm_valid,
    output logic                       dm_ready,
    input  logic [4:0]                 dm_rd,
    input  logic                       dm_rd_we,
    input  logic [BIN_DIG-1:0]         dm_rd_value,
    input  logic [BIN_DIG-1:0]         dm_pc,
    input  logic [BIN_DIG-1:0]         dm_next_pc,
    input  logic                       halt_req,
    output logic [REG_NUM*BIN_DIG-1:0] curr_general_reg,
    output logic [BIN_DIG-1:0]         curr_pc_reg,
    output logic                       redirect_valid,
    output logic [BIN_DIG-1:0]         redirect_pc,
    output logic                       halted,
    output logic                       misalign_err,
    output logic [CNT_W-1:0]           instret
);
    import writeback_stage_pkg::*;

    wb_state_t          state_q, state_d;
    commit_t            hold_q, ex_c, dm_c, cm;
    logic               cm_v, cap, redir;
    logic [BIN_DIG-1:0] npc;

    assign ex_c     = '{ex_rd, ex_rd_we, ex_rd_value, ex_pc, ex_next_pc};
    assign dm_c     = '{dm_rd, dm_rd_we, dm_rd_value, dm_pc, dm_next_pc};
    assign ex_ready = (state_q == WB_RUN);
    assign dm_ready = 1'b1;
    assign halted   = (state_q == WB_HALT);

    always_comb begin
        cm      = '0;
        cm_v    = 1'b0;
        cap     = 1'b0;
        state_d = state_q;
        case (state_q)
            WB_RUN: begin
                // dm is the older instruction when both arrive together
                if (dm_valid) begin
                    cm   = dm_c;
                    cm_v = 1'b1;
                    if (ex_valid) begin
                        cap     = 1'b1;
                        state_d = WB_HOLD;
                    end
                end else if (ex_valid) begin
                    cm   = ex_c;
                    cm_v = 1'b1;
                end
            end
            WB_HOLD: begin
                cm_v = 1'b1;
                if (dm_valid) begin
                    cm = dm_c;
                end else begin
                    cm      = hold_q;
                    state_d = WB_RUN;
                end
            end
            default: ;
        endcase

        npc   = cm.next_pc & ~BIN_DIG'(1);
        redir = cm_v && (npc != cm.pc + BIN_DIG'(4));
        // a redirect means any held (younger) ex result is wrong-path
        if (redir) begin
            cap     = 1'b0;
            state_d = WB_RUN;
        end
        if (state_q != WB_HALT && (halt_req || (cm_v && npc[1]))) begin
            cap     = 1'b0;
            state_d = WB_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= WB_RUN;
            hold_q         <= '0;
            curr_pc_reg    <= RESET_PC;
            instret        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            misalign_err   <= 1'b0;
        end else begin
            state_q        <= state_d;
            redirect_valid <= redir;
            if (cap)
                hold_q <= ex_c;
            if (cm_v) begin
                curr_pc_reg <= npc;
                instret     <= instret + CNT_W'(1);
                if (npc[1])
                    misalign_err <= 1'b1;
            end
            if (redir)
                redirect_pc <= npc;
        end
    end

    writeback_stage_regfile #(.DW(BIN_DIG), .NR(REG_NUM)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cm_v && cm.rd_we),
        .waddr (cm.rd),
        .wdata (cm.rd_value),
        .rdata (curr_general_reg)
    );
endmodule
